// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   state_t  : transaction sequencer states
//   grant_t  : which requester owns the MMU port
//   wd_width : width of the WAIT-state watchdog counter for a given timeout
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin winner select between the fetch and data requesters.
// Ports:
//   i_if_valid   : fetch request pending
//   i_dm_valid   : data request pending
//   i_last_grant : port granted most recently
//   o_grant      : winning port (only meaningful while o_any_req)
//   o_any_req    : at least one request pending
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   i_if_valid,
  input  logic   i_dm_valid,
  input  grant_t i_last_grant,
  output grant_t o_grant,
  output logic   o_any_req
);

  always_comb begin
    o_grant = GNT_IF;
    if (i_if_valid && i_dm_valid) begin
      // Tie: the port that did not win last time goes next.
      if (i_last_grant == GNT_IF) begin
        o_grant = GNT_DM;
      end else begin
        o_grant = GNT_IF;
      end
    end else if (i_dm_valid) begin
      o_grant = GNT_DM;
    end
  end

  assign o_any_req = i_if_valid | i_dm_valid;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the MMU request port between instruction fetch
// and data memory. Each transaction is a one-cycle mem_valid pulse followed
// by a WAIT phase with the request held until mem_ready; a watchdog aborts a
// stalled WAIT after TIMEOUT cycles and sets the sticky arb_err.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   if_*                : fetch requester (read-only)
//   dm_*                : data requester (read/write)
//   mem_*, cache_hit    : MMU request/response port
//   arb_err             : sticky watchdog error
//   perf_*_cnt          : saturating grant / miss counters
// Optional feature: define MEM_ARB_PERF_EN to build the performance counters;
// otherwise the counter outputs are tied to zero.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_r_data,
  input  logic                  dm_valid,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic                  dm_ready,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  input  logic                  mem_ready,
  input  logic                  cache_hit,
  output logic                  arb_err,
  output logic [CNT_WIDTH-1:0]  perf_if_cnt,
  output logic [CNT_WIDTH-1:0]  perf_dm_cnt,
  output logic [CNT_WIDTH-1:0]  perf_miss_cnt
);

  localparam int unsigned WD_WIDTH = wd_width(TIMEOUT);

  state_t                r_state, w_state_next;
  grant_t                r_grant, r_last_grant, w_winner;
  logic                  w_any_req;
  logic                  r_mem_valid, r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_w_data;
  logic [WD_WIDTH-1:0]   r_wd_cnt;
  logic                  r_arb_err;
  logic                  w_timeout, w_done, w_grant_now;

  mem_arb_rr u_rr (
    .i_if_valid   (if_valid),
    .i_dm_valid   (dm_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_winner),
    .o_any_req    (w_any_req)
  );

  assign w_grant_now = (r_state == IDLE) && w_any_req;
  // A real completion in the last allowed cycle takes priority over the watchdog.
  assign w_timeout   = (r_state == WAIT) && !mem_ready && (r_wd_cnt == WD_WIDTH'(TIMEOUT));
  assign w_done      = (r_state == WAIT) && (mem_ready || w_timeout);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= GNT_IF;
      r_last_grant <= GNT_DM;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_w_data <= '0;
      r_wd_cnt     <= '0;
      r_arb_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_now) begin
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
        r_mem_valid  <= 1'b1;
        if (w_winner == GNT_IF) begin
          r_mem_we     <= 1'b0;
          r_mem_addr   <= if_addr;
          r_mem_w_data <= '0;
        end else begin
          r_mem_we     <= dm_we;
          r_mem_addr   <= dm_addr;
          r_mem_w_data <= dm_w_data;
        end
      end
      if (r_state == ISSUE) begin
        r_mem_valid <= 1'b0;
        r_wd_cnt    <= '0;
      end
      if ((r_state == WAIT) && !w_done) begin
        r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
      end
      if (w_timeout) begin
        r_arb_err <= 1'b1;
      end
    end
  end

  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_w_data = r_mem_w_data;

  // Error is visible in the same cycle as the aborting ready pulse, then sticks.
  assign arb_err = r_arb_err | w_timeout;

  assign if_ready  = w_done && (r_grant == GNT_IF);
  assign dm_ready  = w_done && (r_grant == GNT_DM);
  assign if_r_data = w_timeout ? '0 : mem_r_data;
  assign dm_r_data = w_timeout ? '0 : mem_r_data;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] r_perf_if, r_perf_dm, r_perf_miss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_if   <= '0;
      r_perf_dm   <= '0;
      r_perf_miss <= '0;
    end else begin
      if (w_grant_now && (w_winner == GNT_IF) && (r_perf_if != '1)) begin
        r_perf_if <= r_perf_if + CNT_WIDTH'(1);
      end
      if (w_grant_now && (w_winner == GNT_DM) && (r_perf_dm != '1)) begin
        r_perf_dm <= r_perf_dm + CNT_WIDTH'(1);
      end
      if ((r_state == ISSUE) && !r_mem_we && !cache_hit && (r_perf_miss != '1)) begin
        r_perf_miss <= r_perf_miss + CNT_WIDTH'(1);
      end
    end
  end

  assign perf_if_cnt   = r_perf_if;
  assign perf_dm_cnt   = r_perf_dm;
  assign perf_miss_cnt = r_perf_miss;
`else
  logic w_unused_cache_hit;
  assign w_unused_cache_hit = cache_hit;
  assign perf_if_cnt   = '0;
  assign perf_dm_cnt   = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter placed between the CPU core and the `mmu`. It shares the MMU's single memory request port between the instruction-fetch requester and the data-memory requester. Each transaction is sequenced as a single-cycle `mem_valid` pulse, and the arbiter holds the granted request stable until `mem_ready` returns. Requesters are arbitrated round-robin, and the arbiter has a watchdog for a stalled MMU.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, address width
- `TIMEOUT`, 15, maximum cycles in WAIT before the watchdog fires (≥8)
- `CNT_WIDTH`, 16, width of each performance counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_valid`  in  1  fetch request, held until `if_ready`
- `if_addr`  in  ADDR_WIDTH  fetch address (read-only port)
- `if_ready`  out  1  fetch completion, one-cycle pulse
- `if_r_data`  out  DATA_WIDTH  fetch read data, valid while `if_ready`
- `dm_valid`  in  1  data request, held until `dm_ready`
- `dm_we`  in  1  data request is a write
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_w_data`  in  DATA_WIDTH  data write value
- `dm_ready`  out  1  data completion, one-cycle pulse
- `dm_r_data`  out  DATA_WIDTH  data read value, valid while `dm_ready` and not a write
- `mem_valid`  out  1  MMU request pulse
- `mem_we`  out  1  MMU write enable
- `mem_addr`  out  ADDR_WIDTH  MMU address
- `mem_w_data`  out  DATA_WIDTH  MMU write data
- `mem_r_data`  in  DATA_WIDTH  MMU read data
- `mem_ready`  in  1  MMU completion pulse
- `cache_hit`  in  1  MMU hit indication, meaningful while `mem_valid`
- `arb_err`  out  1  sticky watchdog error
- `perf_if_cnt`, `perf_dm_cnt`, `perf_miss_cnt`  out  CNT_WIDTH each  performance counters

## Operation
States:
- IDLE
  - Grant when a request is pending.
  - Latch the winner's `we`, `addr` and `w_data` into registers; `if` forces `we=0`.
  - Set `mem_valid<=1`, go to ISSUE.
- ISSUE
  - `mem_valid` is high for exactly this cycle; `mem_valid<=0`, go to WAIT.
- WAIT
  - Hold `mem_we`, `mem_addr` and `mem_w_data` stable.
  - On `mem_ready`, go to IDLE.
  - If `mem_ready` does not arrive after TIMEOUT cycles in WAIT, set `arb_err=1`, pulse the granted port's ready (r_data = 0) and go to IDLE.

Arbitration and response routing:
- Round robin on a `last_grant` register.
- Single requester: it wins.
- Both requesting: the port opposite `last_grant` wins.
- `last_grant` updates at grant time.
- `x_ready = (state==WAIT) && mem_ready && (grant==x)`, combinational.
- `x_r_data = mem_r_data` for both ports; it is only meaningful while that port's ready is high.
- A `mem_ready` seen outside WAIT is ignored.

Requester rule:
- Valid and request fields stay constant until ready.
- Valid may drop, or a new request may be presented, from the cycle after ready.
- A request that drops early is undefined behaviour and is not checked.

## Timing
Reset values:
- Outputs: `mem_valid`, `mem_we`, `mem_addr` and `mem_w_data` = 0.
- Ready outputs: both readies = 0.
- Status: `arb_err` = 0 and all counters = 0.
- Internal: state = IDLE, `last_grant` = dm, so `if` wins the first tie.

Reset mid-transaction: state returns to IDLE immediately and `mem_valid` drops asynchronously. No ready is produced for the aborted request.

Latency, with the request sampled in IDLE at the end of cycle 0:
- `mem_valid` is high in cycle 1.
- Read hit or write: ready in cycle 2.
- Read miss (4-word fill): ready in cycle 6.
- Watchdog: ready in cycle 2+TIMEOUT.
- The next grant is evaluated in cycle 3 at the earliest, so throughput is one hit per 3 cycles.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - `perf_if_cnt` / `perf_dm_cnt` increment on each grant to their port.
  - `perf_miss_cnt` increments in ISSUE when `!mem_we && !cache_hit`.
  - All three counters saturate at all-ones, with no wrap.
- Not defined: counter logic is omitted and all three outputs are tied to 0.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` {IDLE, ISSUE, WAIT}
  - `grant_t` {GNT_IF, GNT_DM}
  - Watchdog counter width `$clog2(TIMEOUT+1)`
- Sub-module `mem_arb_rr`:
  - Combinational winner select from `if_valid`, `dm_valid` and `last_grant`.
  - Outputs `grant_t` and `any_req`.

## Test plan
- `if_valid`, addr 0x100, MMU hit → `mem_valid` pulses one cycle in cycle 1 with `mem_addr`=0x100; `if_ready` in cycle 2 with `if_r_data`=`mem_r_data`.
- `dm` write to 0x200 with data 0xDEADBEEF → `mem_we`=1 and `mem_w_data`=0xDEADBEEF in cycle 1; `dm_ready` in cycle 2; `if_ready` stays 0.
- Both ports request continuously (reads, all hits) → grants alternate if, dm, if, dm; no port waits more than one transaction; `mem_addr` is stable through each WAIT.
- `dm` read miss at 0x304 → `mem_addr`=0x304 held cycles 1–6; `dm_ready` in cycle 6; with `MEM_ARB_PERF_EN`, `perf_miss_cnt`=1.
- MMU never returns `mem_ready` → `arb_err`=1 and granted ready in cycle 17 (TIMEOUT=15); next request is served normally; `arb_err` stays 1 until reset.
- `rst` asserted in WAIT → `mem_valid`=0, state IDLE, no ready pulse; after release, a pending `if` request is granted first.
